// File: rtl/nts_tx_arbiter_pkg.sv
// Shared NTS definitions used by the TX arbiter, the dispatcher and the extractor.
//   nts_state_t    : arbiter FSM state encoding
//   NTS_LAST_WIDTH : default width of the bytes-in-last-word field
//   nts_idx_width  : width of an engine index, at least one bit
package nts_tx_arbiter_pkg;

  localparam int unsigned NTS_LAST_WIDTH = 4;

  typedef enum logic [1:0] {
    NTS_IDLE    = 2'd0,
    NTS_LOCKED  = 2'd1,
    NTS_RELEASE = 2'd2
  } nts_state_t;

  function automatic int unsigned nts_idx_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/nts_tx_arbiter_if.sv
// Engine-side and extractor-side TX handshake bundle for the NTS TX arbiter.
// Modports:
//   master : the arbiter (reads engine status/data and extractor requests,
//            drives engine strobes and the muxed extractor view)
//   slave  : the environment (engines plus extractor)
interface nts_tx_arbiter_if #(
  parameter int unsigned ENGINES        = 4,
  parameter int unsigned MAC_DATA_WIDTH = 64,
  parameter int unsigned LAST_WIDTH     = nts_tx_arbiter_pkg::NTS_LAST_WIDTH
);

  logic [ENGINES-1:0]                engine_packet_available;
  logic [ENGINES-1:0]                engine_packet_read;
  logic [ENGINES-1:0]                engine_fifo_empty;
  logic [ENGINES-1:0]                engine_fifo_rd_en;
  logic [MAC_DATA_WIDTH*ENGINES-1:0] engine_fifo_rd_data;
  logic [LAST_WIDTH*ENGINES-1:0]     engine_bytes_last_word;

  logic                      extractor_packet_available;
  logic                      extractor_packet_read;
  logic                      extractor_fifo_empty;
  logic                      extractor_fifo_rd_en;
  logic [MAC_DATA_WIDTH-1:0] extractor_fifo_rd_data;
  logic [LAST_WIDTH-1:0]     extractor_bytes_last_word;

  modport master (
    input  engine_packet_available, engine_fifo_empty, engine_fifo_rd_data,
           engine_bytes_last_word, extractor_packet_read, extractor_fifo_rd_en,
    output engine_packet_read, engine_fifo_rd_en, extractor_packet_available,
           extractor_fifo_empty, extractor_fifo_rd_data, extractor_bytes_last_word
  );

  modport slave (
    output engine_packet_available, engine_fifo_empty, engine_fifo_rd_data,
           engine_bytes_last_word, extractor_packet_read, extractor_fifo_rd_en,
    input  engine_packet_read, engine_fifo_rd_en, extractor_packet_available,
           extractor_fifo_empty, extractor_fifo_rd_data, extractor_bytes_last_word
  );

endinterface

// File: rtl/nts_tx_arbiter_rr_select.sv
// Round-robin selector: first set bit of avail scanning upward from ptr with wrap.
// Ports:
//   avail : per-engine request vector
//   ptr   : scan start index (0..ENGINES-1)
//   found : some bit of avail is set
//   idx   : index of the selected engine (0 when nothing found)
module nts_rr_select
  import nts_tx_arbiter_pkg::*;
#(
  parameter  int unsigned ENGINES = 4,
  localparam int unsigned IW      = nts_idx_width(ENGINES)
) (
  input  logic [ENGINES-1:0] avail,
  input  logic [IW-1:0]      ptr,
  output logic               found,
  output logic [IW-1:0]      idx
);

  int unsigned        pos;
  logic [ENGINES-1:0] rot;

  // Candidates are visited in priority order; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    rot   = '0;
    for (int unsigned i = 0; i < ENGINES; i++) begin
      pos = 32'(ptr) + i;
      if (pos >= ENGINES) pos = pos - ENGINES;
      rot = avail >> pos;
      if (!found && rot[0]) begin
        found = 1'b1;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/nts_tx_arbiter.sv
// NTS TX arbiter: grants one engine at a time to the single TX extractor,
// round-robin, holding the grant until the packet completes or the engine
// withdraws it, followed by a one-cycle release gap.
// Ports:
//   i_clk, i_areset     : clock, asynchronous active-high reset
//   bus                 : engine/extractor handshake bundle (master view)
//   o_grant_valid       : a grant is held (LOCKED)
//   o_grant_index       : granted engine; holds its last value outside LOCKED
//   o_packets_forwarded : completed packets, wraps at 2^32
//   o_aborts            : grants abandoned by the engine, saturates at 0xFFFF
module nts_tx_arbiter
  import nts_tx_arbiter_pkg::*;
#(
  parameter  int unsigned ENGINES        = 4,
  parameter  int unsigned MAC_DATA_WIDTH = 64,
  parameter  int unsigned LAST_WIDTH     = NTS_LAST_WIDTH,
  localparam int unsigned IW             = nts_idx_width(ENGINES)
) (
  input  logic                 i_clk,
  input  logic                 i_areset,
  nts_tx_arbiter_if.master     bus,
  output logic                 o_grant_valid,
  output logic [IW-1:0]        o_grant_index,
  output logic [31:0]          o_packets_forwarded,
  output logic [15:0]          o_aborts
);

  nts_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] next_ptr;
  logic [IW-1:0] sel_idx;
  logic          sel_found;
  logic          locked;
  logic          granted_avail;

  assign locked = (state == NTS_LOCKED);

  nts_rr_select #(.ENGINES(ENGINES)) u_rr_select (
    .avail (bus.engine_packet_available),
    .ptr   (rr_ptr),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // Next scan starts just past the engine that was served.
  assign next_ptr = (o_grant_index == IW'(ENGINES - 1)) ? '0 : o_grant_index + IW'(1);

  // Route the granted engine to the extractor and the extractor strobes back;
  // outside LOCKED the extractor sees an empty, idle source.
  always_comb begin
    bus.engine_fifo_rd_en          = '0;
    bus.engine_packet_read         = '0;
    bus.extractor_packet_available = 1'b0;
    bus.extractor_fifo_empty       = 1'b1;
    bus.extractor_fifo_rd_data     = '0;
    bus.extractor_bytes_last_word  = '0;
    granted_avail                  = 1'b0;
    for (int unsigned e = 0; e < ENGINES; e++) begin
      if (locked && (o_grant_index == IW'(e))) begin
        bus.engine_fifo_rd_en[e]       = bus.extractor_fifo_rd_en;
        bus.engine_packet_read[e]      = bus.extractor_packet_read;
        granted_avail                  = bus.engine_packet_available[e];
        bus.extractor_packet_available = bus.engine_packet_available[e];
        bus.extractor_fifo_empty       = bus.engine_fifo_empty[e];
        bus.extractor_fifo_rd_data     = bus.engine_fifo_rd_data[MAC_DATA_WIDTH*e +: MAC_DATA_WIDTH];
        bus.extractor_bytes_last_word  = bus.engine_bytes_last_word[LAST_WIDTH*e +: LAST_WIDTH];
      end
    end
  end

  // Arbitration FSM with registered status outputs.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state               <= NTS_IDLE;
      rr_ptr              <= '0;
      o_grant_valid       <= 1'b0;
      o_grant_index       <= '0;
      o_packets_forwarded <= '0;
      o_aborts            <= '0;
    end else begin
      case (state)
        NTS_IDLE: begin
          if (sel_found) begin
            state         <= NTS_LOCKED;
            o_grant_valid <= 1'b1;
            o_grant_index <= sel_idx;
          end
        end
        NTS_LOCKED: begin
          // Completion takes priority over a simultaneous availability drop.
          if (bus.extractor_packet_read) begin
            state               <= NTS_RELEASE;
            o_grant_valid       <= 1'b0;
            rr_ptr              <= next_ptr;
            o_packets_forwarded <= o_packets_forwarded + 32'd1;
          end else if (!granted_avail) begin
            state         <= NTS_RELEASE;
            o_grant_valid <= 1'b0;
            rr_ptr        <= next_ptr;
            if (o_aborts != 16'hFFFF) o_aborts <= o_aborts + 16'd1;
          end
        end
        NTS_RELEASE: begin
          state <= NTS_IDLE;
        end
        default: begin
          state         <= NTS_IDLE;
          o_grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nts_tx_arbiter.sv
// Directed bench for nts_tx_arbiter: a 4-engine instance and a 1-engine instance.
module tb_nts_tx_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  nts_tx_arbiter_if #(.ENGINES(4), .MAC_DATA_WIDTH(64), .LAST_WIDTH(4)) bus4 ();
  nts_tx_arbiter_if #(.ENGINES(1), .MAC_DATA_WIDTH(64), .LAST_WIDTH(4)) bus1 ();

  logic        gv4;
  logic [1:0]  gi4;
  logic [31:0] pf4;
  logic [15:0] ab4;
  logic        gv1;
  logic [0:0]  gi1;
  logic [31:0] pf1;
  logic [15:0] ab1;

  nts_tx_arbiter #(.ENGINES(4), .MAC_DATA_WIDTH(64), .LAST_WIDTH(4)) u_dut4 (
    .i_clk               (clk),
    .i_areset            (rst),
    .bus                 (bus4),
    .o_grant_valid       (gv4),
    .o_grant_index       (gi4),
    .o_packets_forwarded (pf4),
    .o_aborts            (ab4)
  );

  nts_tx_arbiter #(.ENGINES(1), .MAC_DATA_WIDTH(64), .LAST_WIDTH(4)) u_dut1 (
    .i_clk               (clk),
    .i_areset            (rst),
    .bus                 (bus1),
    .o_grant_valid       (gv1),
    .o_grant_index       (gi1),
    .o_packets_forwarded (pf1),
    .o_aborts            (ab1)
  );

  localparam logic [63:0] D0 = 64'hF0F0_0000_0000_0000;
  localparam logic [63:0] D1 = 64'h1111_0000_0000_0001;
  localparam logic [63:0] D2 = 64'h2222_0000_0000_0002;
  localparam logic [63:0] D3 = 64'h3333_0000_0000_0003;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus4.engine_packet_available = '0;
    bus4.engine_fifo_empty       = 4'b1101;
    bus4.engine_fifo_rd_data     = {D3, D2, D1, D0};
    bus4.engine_bytes_last_word  = {4'd8, 4'd7, 4'd6, 4'd5};
    bus4.extractor_packet_read   = 1'b0;
    bus4.extractor_fifo_rd_en    = 1'b0;
    bus1.engine_packet_available = '0;
    bus1.engine_fifo_empty       = 1'b0;
    bus1.engine_fifo_rd_data     = 64'hABCD_0000_0000_1234;
    bus1.engine_bytes_last_word  = 4'd3;
    bus1.extractor_packet_read   = 1'b0;
    bus1.extractor_fifo_rd_en    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_grant4();
    for (int i = 0; i < 5 && gv4 !== 1'b1; i++) tick();
    check_eq("grant_wait4", 64'(gv4), 64'd1);
  endtask

  task automatic wait_grant1();
    for (int i = 0; i < 5 && gv1 !== 1'b1; i++) tick();
    check_eq("grant_wait1", 64'(gv1), 64'd1);
  endtask

  task automatic pulse_read4();
    bus4.extractor_packet_read = 1'b1;
    tick();
    bus4.extractor_packet_read = 1'b0;
    check_eq("release_gv4", 64'(gv4), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset values, with engines 1 and 3 already requesting.
    rst = 1'b1;
    clear_inputs();
    bus4.engine_packet_available = 4'b1010;
    bus4.extractor_fifo_rd_en    = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rst_gv", 64'(gv4), 64'd0);
    check_eq("rst_gi", 64'(gi4), 64'd0);
    check_eq("rst_pf", 64'(pf4), 64'd0);
    check_eq("rst_ab", 64'(ab4), 64'd0);
    check_eq("rst_x_avail", 64'(bus4.extractor_packet_available), 64'd0);
    check_eq("rst_x_empty", 64'(bus4.extractor_fifo_empty), 64'd1);
    check_eq("rst_x_data", bus4.extractor_fifo_rd_data, 64'd0);
    check_eq("rst_x_bytes", 64'(bus4.extractor_bytes_last_word), 64'd0);
    check_eq("rst_e_rd_en", 64'(bus4.engine_fifo_rd_en), 64'd0);
    check_eq("rst_e_read", 64'(bus4.engine_packet_read), 64'd0);

    // First grant one cycle after reset release; rd_en ignored while idle.
    rst = 1'b0;
    #1;
    check_eq("idle_gv", 64'(gv4), 64'd0);
    check_eq("idle_rd_en_ignored", 64'(bus4.engine_fifo_rd_en), 64'd0);
    tick();
    check_eq("g1_gv", 64'(gv4), 64'd1);
    check_eq("g1_gi", 64'(gi4), 64'd1);
    check_eq("g1_x_avail", 64'(bus4.extractor_packet_available), 64'd1);
    check_eq("g1_x_empty", 64'(bus4.extractor_fifo_empty), 64'd0);
    check_eq("g1_x_data", bus4.extractor_fifo_rd_data, D1);
    check_eq("g1_x_bytes", 64'(bus4.extractor_bytes_last_word), 64'd6);
    check_eq("g1_e_rd_en", 64'(bus4.engine_fifo_rd_en), 64'b0010);
    bus4.extractor_packet_read = 1'b1;
    #1;
    check_eq("g1_e_read", 64'(bus4.engine_packet_read), 64'b0010);
    tick();
    bus4.extractor_packet_read = 1'b0;
    #1;
    check_eq("rel_gv", 64'(gv4), 64'd0);
    check_eq("rel_x_avail", 64'(bus4.extractor_packet_available), 64'd0);
    check_eq("rel_x_empty", 64'(bus4.extractor_fifo_empty), 64'd1);
    check_eq("rel_e_rd_en", 64'(bus4.engine_fifo_rd_en), 64'd0);
    check_eq("rel_pf", 64'(pf4), 64'd1);
    check_eq("rel_gi_hold", 64'(gi4), 64'd1);
    tick();
    check_eq("idle2_gv", 64'(gv4), 64'd0);
    check_eq("idle2_gi_hold", 64'(gi4), 64'd1);
    tick();
    check_eq("g3_gv", 64'(gv4), 64'd1);
    check_eq("g3_gi", 64'(gi4), 64'd3);
    check_eq("g3_x_bytes", 64'(bus4.extractor_bytes_last_word), 64'd8);
    check_eq("g3_x_data", bus4.extractor_fifo_rd_data, D3);
    bus4.extractor_fifo_rd_en = 1'b0;
    pulse_read4();
    check_eq("g3_pf", 64'(pf4), 64'd2);

    // All engines requesting: strict rotation over 8 packets.
    do_reset();
    bus4.engine_packet_available = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_grant4();
      check_eq($sformatf("rr_gi_%0d", k), 64'(gi4), 64'(k % 4));
      pulse_read4();
    end
    check_eq("rr_pf", 64'(pf4), 64'd8);
    check_eq("rr_ab", 64'(ab4), 64'd0);

    // Abort on engine 2, next scan from 3; then read+drop counts as completion.
    do_reset();
    bus4.engine_packet_available = 4'b0100;
    tick();
    check_eq("ab_gi", 64'(gi4), 64'd2);
    bus4.engine_packet_available = 4'b1011;
    #1;
    check_eq("ab_x_avail", 64'(bus4.extractor_packet_available), 64'd0);
    tick();
    check_eq("ab_gv", 64'(gv4), 64'd0);
    check_eq("ab_cnt", 64'(ab4), 64'd1);
    check_eq("ab_pf", 64'(pf4), 64'd0);
    tick();
    tick();
    check_eq("ab_next_gv", 64'(gv4), 64'd1);
    check_eq("ab_next_gi", 64'(gi4), 64'd3);
    bus4.engine_packet_available = 4'b0011;
    pulse_read4();
    check_eq("both_pf", 64'(pf4), 64'd1);
    check_eq("both_ab", 64'(ab4), 64'd1);
    tick();
    tick();
    check_eq("both_next_gi", 64'(gi4), 64'd0);

    // Five-cycle read burst on engine 0.
    do_reset();
    bus4.engine_packet_available = 4'b0001;
    tick();
    check_eq("burst_gi", 64'(gi4), 64'd0);
    for (int i = 0; i < 5; i++) begin
      logic [63:0] exp_d;
      exp_d = 64'h5A5A_0000_0000_0000 + 64'(i);
      bus4.engine_fifo_rd_data[63:0] = exp_d;
      bus4.extractor_fifo_rd_en      = 1'b1;
      #1;
      check_eq($sformatf("burst_rd_en_%0d", i), 64'(bus4.engine_fifo_rd_en), 64'b0001);
      check_eq($sformatf("burst_data_%0d", i), bus4.extractor_fifo_rd_data, exp_d);
      tick();
    end
    bus4.extractor_fifo_rd_en = 1'b0;
    #1;
    check_eq("burst_rd_en_off", 64'(bus4.engine_fifo_rd_en), 64'd0);

    // Reset while locked on engine 2.
    do_reset();
    bus4.engine_packet_available = 4'b0100;
    tick();
    pulse_read4();
    check_eq("mr_pf_pre", 64'(pf4), 64'd1);
    tick();
    tick();
    check_eq("mr_gi_pre", 64'(gi4), 64'd2);
    check_eq("mr_gv_pre", 64'(gv4), 64'd1);
    bus4.extractor_fifo_rd_en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_eq("mr_gv", 64'(gv4), 64'd0);
    check_eq("mr_gi", 64'(gi4), 64'd0);
    check_eq("mr_pf", 64'(pf4), 64'd0);
    check_eq("mr_e_rd_en", 64'(bus4.engine_fifo_rd_en), 64'd0);
    check_eq("mr_x_avail", 64'(bus4.extractor_packet_available), 64'd0);
    check_eq("mr_x_data", bus4.extractor_fifo_rd_data, 64'd0);
    bus4.extractor_fifo_rd_en    = 1'b0;
    bus4.engine_packet_available = 4'b1100;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check_eq("mr_next_gi", 64'(gi4), 64'd2);

    // Single-engine instance, three back-to-back packets.
    do_reset();
    bus1.engine_packet_available = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_grant1();
      check_eq($sformatf("e1_gi_%0d", k), 64'(gi1), 64'd0);
      check_eq($sformatf("e1_x_data_%0d", k), bus1.extractor_fifo_rd_data, 64'hABCD_0000_0000_1234);
      bus1.extractor_packet_read = 1'b1;
      tick();
      bus1.extractor_packet_read = 1'b0;
      check_eq($sformatf("e1_rel_gv_%0d", k), 64'(gv1), 64'd0);
      check_eq($sformatf("e1_rel_empty_%0d", k), 64'(bus1.extractor_fifo_empty), 64'd1);
      tick();
      check_eq($sformatf("e1_idle_gv_%0d", k), 64'(gv1), 64'd0);
    end
    check_eq("e1_pf", 64'(pf1), 64'd3);
    check_eq("e1_ab", 64'(ab1), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
